// File: rtl/wwfa_arbiter_nxn_if.sv
// Request/grant bundle between crossbar input ports and the wave-front arbiter.
// master = port side driving requests, slave = arbiter returning grants.
interface wwfa_arbiter_nxn_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0]        req;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS-1:0]        req_last;
  logic [N_PORTS-1:0]        out_blocked;
  logic [N_PORTS-1:0]        grant;
  logic [N_PORTS*ADDR_W-1:0] grant_out;
  logic [N_PORTS-1:0]        out_busy;
  logic [ADDR_W-1:0]         prio_diag;

  modport master (
    output req, req_addr, req_last, out_blocked,
    input  grant, grant_out, out_busy, prio_diag
  );

  modport slave (
    input  req, req_addr, req_last, out_blocked,
    output grant, grant_out, out_busy, prio_diag
  );
endinterface

// File: rtl/wwfa_arbiter_nxn.sv
// NxN wrapped wave-front arbiter: one-cycle registered grants, optional hold until req_last/abort.
// Blocked outputs get no new grant; held connections ignore out_blocked and req_addr changes.
module wwfa_arbiter_nxn #(
  parameter int N_PORTS = 4,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  wwfa_arbiter_nxn_if.slave bus
);
  localparam int ADDR_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        r_grant;
  logic [N_PORTS*ADDR_W-1:0] r_gout;
  logic [N_PORTS-1:0]        r_busy;
  logic [ADDR_W-1:0]         r_prio;

  logic [N_PORTS-1:0]        w_held;
  logic [N_PORTS-1:0]        w_col_held;
  logic [N_PORTS-1:0]        w_row_free;
  logic [N_PORTS-1:0]        w_col_free;
  logic [N_PORTS-1:0]        w_win;
  logic [N_PORTS*ADDR_W-1:0] w_win_addr;
  logic [N_PORTS-1:0]        w_grant_nxt;
  logic [N_PORTS*ADDR_W-1:0] w_gout_nxt;
  logic [N_PORTS-1:0]        w_busy_nxt;
  logic                      w_rel;
  int                        w_diag;

  assign w_held = HOLD_EN ? r_grant : '0;

  always_comb begin
    w_col_held = '0;
    for (int i = 0; i < N_PORTS; i++)
      for (int j = 0; j < N_PORTS; j++)
        if (w_held[i] && r_gout[i*ADDR_W +: ADDR_W] == ADDR_W'(j))
          w_col_held[j] = 1'b1;
  end

  // Diagonals swept in priority order; each win removes its row and column from later diagonals.
  always_comb begin
    w_row_free = ~w_held;
    w_col_free = ~w_col_held & ~bus.out_blocked;
    w_win      = '0;
    w_win_addr = '0;
    w_diag     = 0;
    for (int d = 0; d < N_PORTS; d++) begin
      w_diag = int'(r_prio) + d;
      if (w_diag >= N_PORTS)
        w_diag = w_diag - N_PORTS;
      for (int i = 0; i < N_PORTS; i++)
        for (int j = 0; j < N_PORTS; j++)
          if ((((j - i) + N_PORTS) % N_PORTS) == w_diag
              && bus.req[i]
              && bus.req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(j)
              && w_row_free[i] && w_col_free[j]) begin
            w_win[i]                        = 1'b1;
            w_win_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(j);
            w_row_free[i]                   = 1'b0;
            w_col_free[j]                   = 1'b0;
          end
    end
  end

  always_comb begin
    w_grant_nxt = '0;
    w_gout_nxt  = '0;
    w_busy_nxt  = '0;
    w_rel       = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_held[i]) begin
        w_rel = !bus.req[i] || bus.req_last[i];
        w_grant_nxt[i] = !w_rel;
        w_gout_nxt[i*ADDR_W +: ADDR_W] = w_rel ? '0 : r_gout[i*ADDR_W +: ADDR_W];
      end else begin
        w_grant_nxt[i] = w_win[i];
        w_gout_nxt[i*ADDR_W +: ADDR_W] = w_win_addr[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 0; i < N_PORTS; i++)
      for (int j = 0; j < N_PORTS; j++)
        if (w_grant_nxt[i] && w_gout_nxt[i*ADDR_W +: ADDR_W] == ADDR_W'(j))
          w_busy_nxt[j] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_gout  <= '0;
      r_busy  <= '0;
      r_prio  <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_gout  <= w_gout_nxt;
      r_busy  <= w_busy_nxt;
      if (|w_win)
        r_prio <= (r_prio == ADDR_W'(N_PORTS - 1)) ? '0 : r_prio + ADDR_W'(1);
    end
  end

  assign bus.grant     = r_grant;
  assign bus.grant_out = r_gout;
  assign bus.out_busy  = r_busy;
  assign bus.prio_diag = r_prio;
endmodule

// File: tb/tb_wwfa_arbiter_nxn.sv
// Directed bench: 4x4 with hold, 4x4 without hold, 3x3 without hold (non-power-of-2 wrap).
module tb_wwfa_arbiter_nxn;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  wwfa_arbiter_nxn_if #(.N_PORTS(4)) b1 ();
  wwfa_arbiter_nxn_if #(.N_PORTS(4)) b0 ();
  wwfa_arbiter_nxn_if #(.N_PORTS(3)) b3 ();

  wwfa_arbiter_nxn #(.N_PORTS(4), .HOLD_EN(1'b1)) u_hold (.clk(clk), .reset(reset), .bus(b1.slave));
  wwfa_arbiter_nxn #(.N_PORTS(4), .HOLD_EN(1'b0)) u_nohold (.clk(clk), .reset(reset), .bus(b0.slave));
  wwfa_arbiter_nxn #(.N_PORTS(3), .HOLD_EN(1'b0)) u_n3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    b1.req = '0; b1.req_addr = '0; b1.req_last = '0; b1.out_blocked = '0;
    b0.req = '0; b0.req_addr = '0; b0.req_last = '0; b0.out_blocked = '0;
    b3.req = '0; b3.req_addr = '0; b3.req_last = '0; b3.out_blocked = '0;

    // reset with all inputs requesting
    reset = 1'b1;
    b1.req = 4'b1111; b1.req_addr = 8'hE4;
    tick();
    chk("rst_grant", 32'(b1.grant), 32'h0);
    chk("rst_busy",  32'(b1.out_busy), 32'h0);
    chk("rst_prio",  32'(b1.prio_diag), 32'h0);
    chk("rst_gout",  32'(b1.grant_out), 32'h0);
    chk("rst_b3prio", 32'(b3.prio_diag), 32'h0);
    reset = 1'b0;
    b1.req = '0; b1.req_addr = '0;

    // single request in0 -> out2, then release via req_last
    b1.req = 4'b0001; b1.req_addr = 8'h02;
    tick();
    chk("single_grant", 32'(b1.grant), 32'h1);
    chk("single_gout",  32'(b1.grant_out), 32'h02);
    chk("single_busy",  32'(b1.out_busy), 32'h4);
    chk("single_prio",  32'(b1.prio_diag), 32'h1);
    b1.req_last = 4'b0001;
    tick();
    chk("last_grant", 32'(b1.grant), 32'h0);
    chk("last_busy",  32'(b1.out_busy), 32'h0);
    chk("last_prio",  32'(b1.prio_diag), 32'h1);
    b1.req = '0; b1.req_last = '0;

    // blocked output: no grant until unblocked; blocking later does not break hold
    b1.out_blocked = 4'b0100; b1.req = 4'b0001; b1.req_addr = 8'h02;
    tick();
    chk("blk_grant_a", 32'(b1.grant), 32'h0);
    chk("blk_prio",    32'(b1.prio_diag), 32'h1);
    tick();
    chk("blk_grant_b", 32'(b1.grant), 32'h0);
    b1.out_blocked = '0;
    tick();
    chk("unblk_grant", 32'(b1.grant), 32'h1);
    chk("unblk_prio",  32'(b1.prio_diag), 32'h2);
    b1.out_blocked = 4'b0100;
    tick();
    chk("heldblk_grant", 32'(b1.grant), 32'h1);
    chk("heldblk_busy",  32'(b1.out_busy), 32'h4);
    b1.req = '0; b1.out_blocked = '0;
    tick();
    chk("abort_grant", 32'(b1.grant), 32'h0);
    chk("abort_prio",  32'(b1.prio_diag), 32'h2);

    // hold: in2->out0 held, in3->out0 waits, one-bubble handover
    b1.req = 4'b0100; b1.req_addr = 8'h00;
    tick();
    chk("hold_grant", 32'(b1.grant), 32'h4);
    chk("hold_busy",  32'(b1.out_busy), 32'h1);
    chk("hold_prio",  32'(b1.prio_diag), 32'h3);
    b1.req = 4'b1100; b1.req_addr = 8'h10;
    tick();
    chk("hold2_grant", 32'(b1.grant), 32'h4);
    chk("hold2_gout",  32'(b1.grant_out), 32'h0);
    chk("hold2_busy",  32'(b1.out_busy), 32'h1);
    tick();
    chk("hold3_grant", 32'(b1.grant), 32'h4);
    b1.req_last = 4'b0100;
    tick();
    chk("bubble_grant", 32'(b1.grant), 32'h0);
    chk("bubble_busy",  32'(b1.out_busy), 32'h0);
    chk("bubble_prio",  32'(b1.prio_diag), 32'h3);
    b1.req = 4'b1000; b1.req_last = '0;
    tick();
    chk("handover_grant", 32'(b1.grant), 32'h8);
    chk("handover_gout",  32'(b1.grant_out), 32'h0);
    chk("handover_busy",  32'(b1.out_busy), 32'h1);
    chk("handover_prio",  32'(b1.prio_diag), 32'h0);
    b1.req = '0;
    tick();
    chk("handover_abort", 32'(b1.grant), 32'h0);

    // full permutation i -> i+1, then abort in1, then mid-transfer reset
    b1.req = 4'b1111; b1.req_addr = 8'h39;
    tick();
    chk("perm_grant", 32'(b1.grant), 32'hF);
    chk("perm_busy",  32'(b1.out_busy), 32'hF);
    chk("perm_gout",  32'(b1.grant_out), 32'h39);
    chk("perm_prio",  32'(b1.prio_diag), 32'h1);
    b1.req = 4'b1101;
    tick();
    chk("perm_drop_grant", 32'(b1.grant), 32'hD);
    chk("perm_drop_busy",  32'(b1.out_busy), 32'hB);
    chk("perm_drop_gout",  32'(b1.grant_out), 32'h31);
    chk("perm_drop_prio",  32'(b1.prio_diag), 32'h1);
    reset = 1'b1;
    tick();
    chk("midrst_grant", 32'(b1.grant), 32'h0);
    chk("midrst_busy",  32'(b1.out_busy), 32'h0);
    chk("midrst_prio",  32'(b1.prio_diag), 32'h0);
    reset = 1'b0;
    b1.req = '0;

    // no hold: in0,in1,in3 -> out1 rotate in1, in0, in3, in1
    b0.req = 4'b1011; b0.req_addr = 8'h45;
    tick();
    chk("rot0_grant", 32'(b0.grant), 32'h2);
    chk("rot0_gout",  32'(b0.grant_out), 32'h04);
    chk("rot0_busy",  32'(b0.out_busy), 32'h2);
    tick();
    chk("rot1_grant", 32'(b0.grant), 32'h1);
    chk("rot1_gout",  32'(b0.grant_out), 32'h01);
    tick();
    chk("rot2_grant", 32'(b0.grant), 32'h8);
    chk("rot2_gout",  32'(b0.grant_out), 32'h40);
    chk("rot2_prio",  32'(b0.prio_diag), 32'h3);
    tick();
    chk("rot3_grant", 32'(b0.grant), 32'h2);
    chk("rot3_prio",  32'(b0.prio_diag), 32'h0);
    b0.req = '0;
    tick();
    chk("rot_idle_grant", 32'(b0.grant), 32'h0);

    // N=3: out-of-range address never granted; prio wraps 2 -> 0
    b3.req = 3'b001; b3.req_addr = 6'b000011;
    tick();
    chk("n3_oor_grant", 32'(b3.grant), 32'h0);
    chk("n3_oor_prio",  32'(b3.prio_diag), 32'h0);
    b3.req_addr = 6'b000000;
    tick();
    chk("n3_grant", 32'(b3.grant), 32'h1);
    chk("n3_busy",  32'(b3.out_busy), 32'h1);
    chk("n3_prio1", 32'(b3.prio_diag), 32'h1);
    tick();
    chk("n3_prio2", 32'(b3.prio_diag), 32'h2);
    tick();
    chk("n3_wrap",  32'(b3.prio_diag), 32'h0);
    b3.req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/wwfa_arbiter_nxn.md
Name: wwfa_arbiter_nxn

Overview:
Parametrised N-input x N-output wrapped wave-front arbiter for the crossbar switch. It allocates input->output connections, one output per input and one input per output. Allocation uses a rotating-priority diagonal sweep. Grants are registered and can be held across multi-cycle packets. It replaces the fixed 4x4 point-cell array, and adds arbitrary port count, grant hold/release, and fairness rotation driven by actual grants.

Parameters:
N_PORTS, 4, number of inputs = number of outputs (>=2).
ADDR_W, $clog2(N_PORTS), localparam, destination index width.
HOLD_EN, 1, 1 = grants held until released by req_last; 0 = grants recomputed every cycle.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
req  in  N_PORTS  per-input request valid.
req_addr  in  N_PORTS*ADDR_W  per-input destination output index; input i uses bits [i*ADDR_W +: ADDR_W].
req_last  in  N_PORTS  per-input end of current transfer; only meaningful while that input is granted.
out_blocked  in  N_PORTS  per-output backpressure; a blocked output receives no new grant.
grant  out  N_PORTS  per-input registered grant.
grant_out  out  N_PORTS*ADDR_W  granted output index per input; 0 when not granted.
out_busy  out  N_PORTS  per-output "currently allocated" flag.
prio_diag  out  ADDR_W  current top-priority diagonal.

Behaviour:
- Single clock domain; everything updates on posedge clk. Reset is synchronous and active-high.
- Reset: grant=0, grant_out=0, out_busy=0, prio_diag=0, all hold state cleared. Reset asserted mid-transfer drops all connections at that edge.
- Cell (i,j) is on diagonal (j - i) mod N_PORTS.
- need(i,j) = req[i] & (req_addr_i == j) & input i not held.
- A req_addr value >= N_PORTS matches no cell, so that input is never granted.
- Input free = not held. Output free = not held and out_blocked[j]=0.
- Wave order: diagonals are evaluated prio_diag, prio_diag+1, ... wrapping mod N_PORTS, all N diagonals in one cycle (combinational).
- Cells on one diagonal share no row or column.
- Cell (i,j) wins if need(i,j), row i still free and column j still free. A win consumes row i and column j for later diagonals.
- Latency: request sampled in cycle t -> grant/grant_out/out_busy visible in cycle t+1.
- HOLD_EN=1: per-input state IDLE/HELD.
  - IDLE->HELD on win.
  - HELD->IDLE when grant[i]&req_last[i], or when req[i]=0 (abort).
  - While HELD: grant[i]=1, and grant_out[i] keeps the latched index; req_addr changes are ignored.
  - out_blocked does not break a held connection.
  - Release in cycle t: grant drops at t+1. The freed output is arbitrated in cycle t+1, so a new grant is visible at t+2 (one bubble).
  - Arbitration in cycle t always uses pre-release state.
- HOLD_EN=0: no held state and req_last is ignored. Each cycle's grants depend only on that cycle's req, req_addr, out_blocked and prio_diag.
- Rotation: prio_diag <= prio_diag+1 (mod N_PORTS) on each edge where at least one new win occurred; otherwise it is unchanged.
- Wrap: prio_diag at N_PORTS-1 wraps to 0, including for non-power-of-2 N_PORTS.
- out_busy[j] = OR over inputs of (grant[i] & grant_out_i==j). At most one grant per output and one output per input, at all times.

Test Plan:
1. Reset with req=4'b1111 -> cycle after reset: grant=0, out_busy=0, prio_diag=0.
2. N=4, req=4'b0001, in0->out2 at cycle 0 -> cycle 1: grant=4'b0001, grant_out[0]=2, out_busy=4'b0100, prio_diag=1.
3. HOLD_EN=0, in0,in1,in3 all ->out1 held constant -> winners in successive cycles: in1 (diag0), in0 (diag1), in3 (diag2), then in1 (prio_diag=3 has no candidate, so the wave reaches diag0).
4. out_blocked=4'b0100, in0->out2 -> no grant while blocked; clear out_blocked at cycle 5 -> grant[0]=1 at cycle 6.
5. HOLD_EN=1, in2->out0 granted at cycle 1, in3->out0 pending:
   - grant[3]=0 through the hold.
   - req_last[2]=1 at cycle 3 -> grant[2]=0 at cycle 4.
   - grant[3]=1, grant_out[3]=0 at cycle 5.
6. Permutation in i -> out (i+1) mod 4, all requests simultaneous -> next cycle grant=4'b1111, out_busy=4'b1111; then req[1]=0 -> only grant[1] drops next cycle.
